icache_refill_ctrl: RTL and testbench

//  Refill engine directly upstream of the instruction-cache sets. On an I-cache miss it issues one

---
 rtl/icache_pkg.sv | 21 ++
 rtl/refill_buffer.sv | 26 ++
 rtl/icache_refill_ctrl.sv | 124 ++++++++++++
 tb/tb_icache_refill_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and defaults for the instruction-cache refill path.
// Refill states are one-hot so each state test is a single flop.
package icache_pkg;

   localparam int ICACHE_BLOCK_BYTES = 64;
   localparam int ICACHE_ADDR_W      = 32;
   localparam int ICACHE_WORD_W      = 64;

   typedef enum logic [4:0] {
      IDLE    = 5'b00001,
      REQUEST = 5'b00010,
      FILL    = 5'b00100,
      STREAM  = 5'b01000,
      DONE    = 5'b10000
   } refill_state_t;

   function automatic int words_per_block(input int bytes);
      return bytes / (ICACHE_WORD_W / 8);
   endfunction

endpackage

// File: rtl/refill_buffer.sv
// Block staging buffer: one 64-bit word per entry.
// Synchronous write, asynchronous read, no reset (contents don't-care).
module refill_buffer #(
   parameter int WORDS = 8,
   parameter int W     = 64,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache refill engine: one block read from L2, buffered, then
// streamed to the missing set as a bubble-free grant burst.
module icache_refill_ctrl
   import icache_pkg::*;
#(
   parameter int B      = ICACHE_BLOCK_BYTES,
   parameter int ADDR_W = ICACHE_ADDR_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              ic_miss_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_req_ready_i,
   input  logic              mem_rvalid_i,
   input  logic [63:0]       mem_rdata_i,
   output logic              ic_repl_grant_o,
   output logic [63:0]       rep_word_o,
   output logic              refill_busy_o
);

   localparam int WORDS = words_per_block(B);
   localparam int CW    = $clog2(WORDS);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t LAST = cnt_t'(WORDS - 1);
   localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(B - 1);

   refill_state_t     state;
   refill_state_t     state_nxt;
   logic [ADDR_W-1:0] blk_addr;
   cnt_t              fill_cnt;
   cnt_t              str_cnt;

   logic              req;
   logic              grant;
   logic              busy;
   logic              wr_en;
   logic [63:0]       rd_data;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state    <= IDLE;
         blk_addr <= '0;
         fill_cnt <= '0;
         str_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && ic_miss_i) begin
            blk_addr <= ic_addr_i & BLK_MASK;
         end
         // Power-of-two depth: the increment past LAST wraps to 0
         if (wr_en) begin
            fill_cnt <= fill_cnt + 1'b1;
         end
         if (grant) begin
            str_cnt <= str_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      grant     = 1'b0;
      wr_en     = 1'b0;
      busy      = 1'b1;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (ic_miss_i) begin
               state_nxt = REQUEST;
            end
         end
         REQUEST: begin
            req = 1'b1;
            if (mem_req_ready_i) begin
               state_nxt = FILL;
            end
         end
         FILL: begin
            wr_en = mem_rvalid_i;
            if (mem_rvalid_i && fill_cnt == LAST) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            grant = 1'b1;
            if (str_cnt == LAST) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   refill_buffer #(
      .WORDS (WORDS),
      .W     (64)
   ) u_buf (
      .clk   (clk_i),
      .we    (wr_en),
      .waddr (fill_cnt),
      .wdata (mem_rdata_i),
      .raddr (str_cnt),
      .rdata (rd_data)
   );

   // Outputs decode straight from state so reset clears them at once
   assign mem_req_o       = req;
   assign mem_addr_o      = req ? blk_addr : '0;
   assign ic_repl_grant_o = grant;
   assign rep_word_o      = grant ? rd_data : '0;
   assign refill_busy_o   = busy;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl at B=64 and B=16.
// Expected values come from a transaction-level model of each refill.
module tb_icache_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        miss = 1'b0;
   logic [31:0] addr = '0;
   logic        ready = 1'b0;
   logic        rvalid = 1'b0;
   logic [63:0] rdata = '0;

   logic        req64, req16, gnt64, gnt16, busy64, busy16;
   logic [31:0] maddr64, maddr16;
   logic [63:0] word64, word16;

   logic        o_req, o_gnt, o_busy;
   logic [31:0] o_maddr;
   logic [63:0] o_word;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   icache_refill_ctrl #(.B(64), .ADDR_W(32)) dut64 (
      .clk_i           (clk),
      .reset_i         (rst),
      .ic_miss_i       (miss & ~sel),
      .ic_addr_i       (addr),
      .mem_req_o       (req64),
      .mem_addr_o      (maddr64),
      .mem_req_ready_i (ready),
      .mem_rvalid_i    (rvalid),
      .mem_rdata_i     (rdata),
      .ic_repl_grant_o (gnt64),
      .rep_word_o      (word64),
      .refill_busy_o   (busy64)
   );

   icache_refill_ctrl #(.B(16), .ADDR_W(32)) dut16 (
      .clk_i           (clk),
      .reset_i         (rst),
      .ic_miss_i       (miss & sel),
      .ic_addr_i       (addr),
      .mem_req_o       (req16),
      .mem_addr_o      (maddr16),
      .mem_req_ready_i (ready),
      .mem_rvalid_i    (rvalid),
      .mem_rdata_i     (rdata),
      .ic_repl_grant_o (gnt16),
      .rep_word_o      (word16),
      .refill_busy_o   (busy16)
   );

   assign o_req   = sel ? req16   : req64;
   assign o_gnt   = sel ? gnt16   : gnt64;
   assign o_busy  = sel ? busy16  : busy64;
   assign o_maddr = sel ? maddr16 : maddr64;
   assign o_word  = sel ? word16  : word64;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // One full refill as the model sees it: block address, one request,
   // accepted beats in order, WORDS grant cycles, one DONE cycle.
   task automatic do_refill(input logic [31:0] a, input int stall,
                            input int max_gap, input bit seq_data,
                            input bit hold);
      int          words;
      int          bytes;
      logic [31:0] exp_addr;
      logic [63:0] q[$];
      logic [63:0] d;
      words    = sel ? 2 : 8;
      bytes    = words * 8;
      exp_addr = a & ~(32'(bytes) - 32'd1);
      q        = {};

      check("idle_busy", o_busy, 1'b0);
      miss   = 1'b1;
      addr   = a;
      rvalid = 1'b1;
      rdata  = 64'hDEAD;
      step();
      rvalid = 1'b0;
      if (!hold) begin
         miss = 1'b0;
         addr = $urandom;
      end

      for (int i = 0; i <= stall; i++) begin
         check($sformatf("req%0d", i), o_req, 1'b1);
         check($sformatf("addr%0d", i), o_maddr, exp_addr);
         check($sformatf("req_gnt%0d", i), o_gnt, 1'b0);
         ready = (i == stall);
         if (i == stall) begin
            rvalid = 1'b1;
            rdata  = 64'hDEAD;
         end
         step();
      end
      ready  = 1'b0;
      rvalid = 1'b0;

      for (int w = 0; w < words; w++) begin
         int gap;
         gap = $urandom_range(0, max_gap);
         for (int g = 0; g < gap; g++) begin
            check("fill_req", o_req, 1'b0);
            check("fill_gnt", o_gnt, 1'b0);
            step();
         end
         check("fill_busy", o_busy, 1'b1);
         check("fill_req", o_req, 1'b0);
         d      = seq_data ? 64'(w) : {$urandom, $urandom};
         rvalid = 1'b1;
         rdata  = d;
         q.push_back(d);
         step();
         rvalid = 1'b0;
      end

      for (int k = 0; k < words; k++) begin
         check($sformatf("gnt%0d", k), o_gnt, 1'b1);
         check($sformatf("word%0d", k), o_word, q[k]);
         rvalid = $urandom_range(0, 1) == 1;
         rdata  = 64'hDEAD;
         step();
      end
      rvalid = 1'b0;

      check("done_gnt", o_gnt, 1'b0);
      check("done_word", o_word, 64'h0);
      check("done_busy", o_busy, 1'b1);
      check("done_req", o_req, 1'b0);
      step();
      check("after_busy", o_busy, 1'b0);
      check("after_req", o_req, 1'b0);
   endtask

   initial begin
      logic [31:0] a;
      step();
      check("rst_busy", o_busy, 1'b0);
      check("rst_req", o_req, 1'b0);
      check("rst_gnt", o_gnt, 1'b0);
      check("rst_word", o_word, 64'h0);
      step();
      rst = 1'b0;
      step();

      // Mid-FILL reset clears outputs without waiting for a clock
      miss = 1'b1;
      addr = 32'h0000_4444;
      step();
      miss  = 1'b0;
      ready = 1'b1;
      step();
      ready  = 1'b0;
      rvalid = 1'b1;
      rdata  = 64'h1111;
      step();
      step();
      rvalid = 1'b0;
      check("mid_fill_busy", o_busy, 1'b1);
      rst = 1'b1;
      #1;
      check("arst_busy", o_busy, 1'b0);
      check("arst_req", o_req, 1'b0);
      check("arst_addr", o_maddr, 32'h0);
      check("arst_gnt", o_gnt, 1'b0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("post_rst_busy", o_busy, 1'b0);
         check("post_rst_gnt", o_gnt, 1'b0);
      end

      do_refill(32'h0000_1234, 0, 0, 1'b1, 1'b0);
      do_refill(32'h0000_5678, 4, 2, 1'b0, 1'b0);

      a = $urandom;
      do_refill(a, 1, 1, 1'b0, 1'b1);
      do_refill(a, 0, 0, 1'b0, 1'b0);

      for (int n = 0; n < 6; n++) begin
         do_refill($urandom, $urandom_range(0, 4), 3, 1'b0, 1'b0);
      end

      sel = 1'b1;
      step();
      do_refill(32'h0000_1234, 0, 0, 1'b1, 1'b0);
      for (int n = 0; n < 6; n++) begin
         do_refill($urandom, $urandom_range(0, 3), 3, 1'b0, n == 2);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
